cga_attrib_pipe: RTL and testbench

- Registered, parametrised successor to the combinational CGA attribute/colour stage.
- Converts text attribute/dot or graphics pixel data (1, 2 or 4 bpp) into a 4-bit logical colour index.
- Applies character blink with a programmable divider, then maps the index through a writable 16-entry palette to an OUT_BITS-wide colour.
- Sits between the pixel shifter and the video DAC/scan-doubler; fixed 2-cycle latency.

---
 rtl/cga_attrib_if.sv | 39 +++
 rtl/cga_attrib_pipe.sv | 107 ++++++++++
 tb/tb_cga_attrib_pipe.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cga_attrib_if.sv
// Pixel-side bus of the CGA attribute pipeline: mode/attribute inputs,
// palette write port and the mapped colour output.
interface cga_attrib_if #(
    parameter int unsigned OUT_BITS = 4
);
    logic [7:0]          att_byte;
    logic                pix_in;
    logic [3:0]          gfx_pix;
    logic [1:0]          gfx_bpp;
    logic                grph_mode;
    logic                pal_sel;
    logic                bright;
    logic [3:0]          border_color;
    logic                display_enable;
    logic                blink_enabled;
    logic                blink;
    logic                cursor;
    logic                hsync;
    logic                vsync;
    logic                pal_we;
    logic [3:0]          pal_addr;
    logic [OUT_BITS-1:0] pal_data;
    logic [OUT_BITS-1:0] pix_out;
    logic                blank_out;

    modport master (
        output att_byte, pix_in, gfx_pix, gfx_bpp, grph_mode, pal_sel, bright,
               border_color, display_enable, blink_enabled, blink, cursor,
               hsync, vsync, pal_we, pal_addr, pal_data,
        input  pix_out, blank_out
    );

    modport slave (
        input  att_byte, pix_in, gfx_pix, gfx_bpp, grph_mode, pal_sel, bright,
               border_color, display_enable, blink_enabled, blink, cursor,
               hsync, vsync, pal_we, pal_addr, pal_data,
        output pix_out, blank_out
    );
endinterface

// File: rtl/cga_attrib_pipe.sv
// Two-stage CGA attribute/colour pipeline: stage 1 resolves a 4-bit logical
// index (text, 1/2/4 bpp graphics, border, sync), stage 2 maps it through a
// writable 16-entry palette.
module cga_attrib_pipe #(
    parameter int unsigned OUT_BITS  = 4,
    parameter int unsigned BLINK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    cga_attrib_if.slave bus
);
    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned PAL_N = 16;

    logic [CNT_W-1:0]    blink_cnt;
    logic                blink_old;
    logic                blinkdiv;
    logic [3:0]          idx1;
    logic                blank1;
    logic [3:0]          idx_c;
    logic                sync_c;
    logic [OUT_BITS-1:0] pal [PAL_N];
    logic [OUT_BITS-1:0] pix_q;
    logic                blank_q;

    // Character-blink phase: toggles every BLINK_DIV rising edges of blink.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_old <= 1'b0;
            blink_cnt <= '0;
            blinkdiv  <= 1'b0;
        end else begin
            blink_old <= bus.blink;
            if (bus.blink && !blink_old) begin
                if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    blinkdiv  <= ~blinkdiv;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Logical colour index selection for the current dot.
    always_comb begin
        logic       dot;
        logic [3:0] bg;
        idx_c  = 4'h0;
        dot    = 1'b0;
        bg     = 4'h0;
        sync_c = bus.hsync | bus.vsync;
        if (sync_c) begin
            idx_c = 4'h0;
        end else if (!bus.display_enable) begin
            idx_c = bus.border_color;
        end else if (!bus.grph_mode) begin
            bg  = bus.blink_enabled ? {1'b0, bus.att_byte[6:4]} : bus.att_byte[7:4];
            dot = (bus.pix_in & ~(bus.blink_enabled & bus.att_byte[7] & ~bus.cursor & blinkdiv))
                | (bus.cursor & bus.blink);
            idx_c = dot ? bus.att_byte[3:0] : bg;
        end else begin
            unique case (bus.gfx_bpp)
                2'd0:    idx_c = bus.gfx_pix[0] ? bus.border_color : 4'h0;
                2'd1:    idx_c = (bus.gfx_pix[1:0] == 2'b00) ? bus.border_color
                               : {bus.bright, bus.gfx_pix[1], bus.gfx_pix[0], bus.pal_sel};
                default: idx_c = bus.gfx_pix;
            endcase
        end
    end

    // Stage 1 register: index and blank flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx1   <= 4'h0;
            blank1 <= 1'b1;
        end else begin
            idx1   <= idx_c;
            blank1 <= sync_c;
        end
    end

    // Palette storage; a same-edge read sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(PAL_N); i++) begin
                pal[i] <= OUT_BITS'(i);
            end
        end else if (bus.pal_we) begin
            pal[bus.pal_addr] <= bus.pal_data;
        end
    end

    // Stage 2 register: palette lookup and blank alignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q   <= '0;
            blank_q <= 1'b1;
        end else begin
            pix_q   <= blank1 ? '0 : pal[idx1];
            blank_q <= blank1;
        end
    end

    assign bus.pix_out   = pix_q;
    assign bus.blank_out = blank_q;
endmodule

// File: tb/tb_cga_attrib_pipe.sv
// Directed bench for cga_attrib_pipe with hand-computed expected colours.
module tb_cga_attrib_pipe;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cga_attrib_if #(.OUT_BITS(4)) bus ();

    cga_attrib_pipe #(.OUT_BITS(4), .BLINK_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic blink_edge();
        bus.blink = 1'b1;
        tick();
        bus.blink = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.att_byte = 8'h00;       bus.pix_in = 1'b0;
        bus.gfx_pix = 4'h0;         bus.gfx_bpp = 2'd0;
        bus.grph_mode = 1'b0;       bus.pal_sel = 1'b0;
        bus.bright = 1'b0;          bus.border_color = 4'h0;
        bus.display_enable = 1'b0;  bus.blink_enabled = 1'b0;
        bus.blink = 1'b0;           bus.cursor = 1'b0;
        bus.hsync = 1'b0;           bus.vsync = 1'b0;
        bus.pal_we = 1'b0;          bus.pal_addr = 4'h0;
        bus.pal_data = 4'h0;
        tick();
        tick();
        check("reset_pix", 8'(bus.pix_out), 8'h0);
        check("reset_blank", 8'(bus.blank_out), 8'h1);
        reset = 1'b0;

        // Text, no blink: fg then bg, 2-cycle latency.
        bus.display_enable = 1'b1;
        bus.att_byte = 8'h1E;
        bus.pix_in = 1'b1;
        tick();
        bus.pix_in = 1'b0;
        tick();
        check("text_fg", 8'(bus.pix_out), 8'h0E);
        check("text_fg_blank", 8'(bus.blank_out), 8'h0);
        tick();
        check("text_bg", 8'(bus.pix_out), 8'h01);

        // Blinking attribute: bg appears after 2nd blink edge, fg after 4th.
        bus.att_byte = 8'h9E;
        bus.blink_enabled = 1'b1;
        bus.pix_in = 1'b1;
        tick();
        tick();
        check("blink_phase0", 8'(bus.pix_out), 8'h0E);
        blink_edge();
        tick();
        tick();
        check("blink_edge1", 8'(bus.pix_out), 8'h0E);
        blink_edge();
        tick();
        tick();
        check("blink_edge2", 8'(bus.pix_out), 8'h01);
        blink_edge();
        blink_edge();
        tick();
        tick();
        check("blink_edge4", 8'(bus.pix_out), 8'h0E);

        // Graphics 2bpp with bright/pal_sel set.
        bus.blink_enabled = 1'b0;
        bus.grph_mode = 1'b1;
        bus.gfx_bpp = 2'd1;
        bus.bright = 1'b1;
        bus.pal_sel = 1'b1;
        bus.border_color = 4'h3;
        bus.gfx_pix = 4'h0;
        tick();
        bus.gfx_pix = 4'h1;
        tick();
        check("g2_pix0", 8'(bus.pix_out), 8'h03);
        bus.gfx_pix = 4'h2;
        tick();
        check("g2_pix1", 8'(bus.pix_out), 8'h0B);
        bus.gfx_pix = 4'h3;
        tick();
        check("g2_pix2", 8'(bus.pix_out), 8'h0D);
        tick();
        check("g2_pix3", 8'(bus.pix_out), 8'h0F);

        // Graphics 1bpp: set dot takes border colour, clear dot is 0.
        bus.gfx_bpp = 2'd0;
        bus.gfx_pix = 4'h1;
        tick();
        bus.gfx_pix = 4'h0;
        tick();
        check("g1_set", 8'(bus.pix_out), 8'h03);
        tick();
        check("g1_clear", 8'(bus.pix_out), 8'h00);

        // Palette write colliding with a read of the same entry.
        bus.gfx_bpp = 2'd2;
        bus.gfx_pix = 4'h5;
        tick();
        bus.pal_we = 1'b1;
        bus.pal_addr = 4'h5;
        bus.pal_data = 4'hA;
        tick();
        check("pal_old", 8'(bus.pix_out), 8'h05);
        bus.pal_we = 1'b0;
        tick();
        check("pal_new", 8'(bus.pix_out), 8'h0A);

        // Sync blanks; border shows outside active display.
        bus.grph_mode = 1'b0;
        bus.att_byte = 8'h1E;
        bus.pix_in = 1'b1;
        bus.hsync = 1'b1;
        tick();
        tick();
        check("sync_pix", 8'(bus.pix_out), 8'h00);
        check("sync_blank", 8'(bus.blank_out), 8'h1);
        bus.hsync = 1'b0;
        bus.display_enable = 1'b0;
        bus.border_color = 4'h6;
        tick();
        tick();
        check("border_pix", 8'(bus.pix_out), 8'h06);
        check("border_blank", 8'(bus.blank_out), 8'h0);

        // Leave blink state dirty (blinkdiv=1, counter=1) before reset.
        bus.display_enable = 1'b1;
        blink_edge();
        blink_edge();
        blink_edge();

        // Reset with a concurrent palette write: reset wins.
        bus.grph_mode = 1'b1;
        bus.gfx_bpp = 2'd2;
        bus.gfx_pix = 4'h5;
        bus.pal_we = 1'b1;
        bus.pal_addr = 4'h5;
        bus.pal_data = 4'hC;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.pal_we = 1'b0;
        check("rst_out0_pix", 8'(bus.pix_out), 8'h00);
        check("rst_out0_blank", 8'(bus.blank_out), 8'h1);
        tick();
        check("rst_out1_pix", 8'(bus.pix_out), 8'h00);
        check("rst_out1_blank", 8'(bus.blank_out), 8'h1);
        tick();
        check("rst_pal_identity", 8'(bus.pix_out), 8'h05);
        check("rst_out2_blank", 8'(bus.blank_out), 8'h0);

        // Blink state cleared: fg now, still fg after one edge, bg after two.
        bus.grph_mode = 1'b0;
        bus.att_byte = 8'h9E;
        bus.blink_enabled = 1'b1;
        bus.pix_in = 1'b1;
        tick();
        tick();
        check("rst_blinkdiv0", 8'(bus.pix_out), 8'h0E);
        blink_edge();
        tick();
        tick();
        check("rst_blink_cnt0", 8'(bus.pix_out), 8'h0E);
        blink_edge();
        tick();
        tick();
        check("rst_blink_toggle", 8'(bus.pix_out), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
